// File: rtl/hazard_detection_unit.sv
// -----------------------------------------------------------------------------
// hazard_detection_unit
//
// ID-stage hazard controller for the 5-stage, 16-register pipeline. It stalls
// or bubbles the front end whenever the EX/MEM bypass network cannot deliver
// an operand in time. It also flushes IF/ID on taken branches and keeps a
// sticky halt indication.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   MemRead_IDEX        EX instruction is a load
//   RegWrite_IDEX       EX instruction writes a register
//   FlagWrite_IDEX      EX instruction updates flags
//   DstReg_IDEX         EX destination register
//   SrcReg1/2_IFID      ID source registers
//   uses_src1/2         ID instruction reads the matching source
//   is_store_IFID       ID instruction is SW (src2 is store data)
//   is_br_IFID          ID instruction is BR (register target)
//   is_b_IFID           ID instruction is B (flag condition)
//   branch_taken_ID     ID branch resolves taken
//   imem_busy           instruction memory not ready
//   dmem_busy           data memory not ready
//   hlt_MEMWB           HLT has reached WB
//   pc_stall            hold PC
//   ifid_stall          hold IF/ID
//   ifid_flush          load NOP into IF/ID
//   idex_bubble         load NOP into ID/EX
//   pipe_freeze         hold ID/EX, EX/MEM, MEM/WB
//   halted              sticky halt
// -----------------------------------------------------------------------------
module hazard_detection_unit #(
   parameter int REG_ID_W       = 4,
   parameter int LOAD_BR_STALLS = 2,
   parameter int ALU_BR_STALLS  = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                MemRead_IDEX,
   input  logic                RegWrite_IDEX,
   input  logic                FlagWrite_IDEX,
   input  logic [REG_ID_W-1:0] DstReg_IDEX,
   input  logic [REG_ID_W-1:0] SrcReg1_IFID,
   input  logic [REG_ID_W-1:0] SrcReg2_IFID,
   input  logic                uses_src1,
   input  logic                uses_src2,
   input  logic                is_store_IFID,
   input  logic                is_br_IFID,
   input  logic                is_b_IFID,
   input  logic                branch_taken_ID,
   input  logic                imem_busy,
   input  logic                dmem_busy,
   input  logic                hlt_MEMWB,
   output logic                pc_stall,
   output logic                ifid_stall,
   output logic                ifid_flush,
   output logic                idex_bubble,
   output logic                pipe_freeze,
   output logic                halted
);

   // The counter holds the stall cycles that remain after the current one,
   // so a hazard needing N cycles loads N-1.
   localparam logic [1:0] LOAD_BR_CNT = 2'(LOAD_BR_STALLS - 1);
   localparam logic [1:0] ALU_BR_CNT  = 2'(ALU_BR_STALLS - 1);

   logic [1:0] stall_cnt_q, stall_cnt_d;
   logic       halted_q, halted_d;

   logic       src1_match, src2_match;
   logic       load_use_hz, br_reg_hz, b_flag_hz, any_hz;
   logic [1:0] br_cnt, hz_cnt;
   logic       branch_taken;

   // Register 0 is hardwired zero, so it never matches.
   assign src1_match = (SrcReg1_IFID == DstReg_IDEX) && (SrcReg1_IFID != '0);
   assign src2_match = (SrcReg2_IFID == DstReg_IDEX) && (SrcReg2_IFID != '0);

   // Store data (src2 of SW) is bypassed MEM-to-MEM, so it never load-stalls.
   assign load_use_hz = MemRead_IDEX &&
                        ((uses_src1 && src1_match) ||
                         (uses_src2 && !is_store_IFID && src2_match));
   assign br_reg_hz   = is_br_IFID && RegWrite_IDEX && src1_match;
   assign b_flag_hz   = is_b_IFID && FlagWrite_IDEX;
   assign any_hz      = load_use_hz || br_reg_hz || b_flag_hz;

   assign br_cnt       = MemRead_IDEX ? LOAD_BR_CNT : ALU_BR_CNT;
   assign branch_taken = (is_br_IFID || is_b_IFID) && branch_taken_ID;

   // Concurrent hazards do not accumulate: the longest one wins. A load-use
   // hazard contributes 0 because the bypass covers the following cycle.
   always_comb begin
      hz_cnt = '0;
      if (br_reg_hz && (br_cnt > hz_cnt)) begin
         hz_cnt = br_cnt;
      end
      if (b_flag_hz && (ALU_BR_CNT > hz_cnt)) begin
         hz_cnt = ALU_BR_CNT;
      end
   end

   always_comb begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pipe_freeze = 1'b0;
      stall_cnt_d = stall_cnt_q;
      halted_d    = halted_q | hlt_MEMWB;

      if (halted_q) begin
         pc_stall   = 1'b1;
         ifid_stall = 1'b1;
      end else if (dmem_busy) begin
         // Whole pipe waits on data memory; a counted stall pauses here.
         pc_stall    = 1'b1;
         ifid_stall  = 1'b1;
         pipe_freeze = 1'b1;
      end else if (stall_cnt_q != '0) begin
         // Branch outcome is not trusted until the operand has arrived.
         pc_stall    = 1'b1;
         ifid_stall  = 1'b1;
         idex_bubble = 1'b1;
         stall_cnt_d = stall_cnt_q - 2'd1;
      end else if (any_hz) begin
         pc_stall    = 1'b1;
         ifid_stall  = 1'b1;
         idex_bubble = 1'b1;
         stall_cnt_d = hz_cnt;
      end else begin
         if (branch_taken) begin
            ifid_flush = 1'b1;
         end
         // Fetch not ready: hold PC and feed a NOP into ID. When combined
         // with a taken branch this is still a single flush.
         if (imem_busy) begin
            pc_stall   = 1'b1;
            ifid_flush = 1'b1;
         end
      end
   end

   assign halted = halted_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         halted_q    <= 1'b0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         halted_q    <= halted_d;
      end
   end

endmodule

// File: tb/tb_hazard_detection_unit.sv
module tb_hazard_detection_unit;

   localparam int REG_ID_W       = 4;
   localparam int LOAD_BR_STALLS = 2;
   localparam int ALU_BR_STALLS  = 1;

   logic                clk;
   logic                rst_n;
   logic                MemRead_IDEX, RegWrite_IDEX, FlagWrite_IDEX;
   logic [REG_ID_W-1:0] DstReg_IDEX, SrcReg1_IFID, SrcReg2_IFID;
   logic                uses_src1, uses_src2, is_store_IFID, is_br_IFID, is_b_IFID;
   logic                branch_taken_ID, imem_busy, dmem_busy, hlt_MEMWB;
   logic                pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, halted;

   int checks   = 0;
   int failures = 0;

   // Behavioural model state: remaining extra stall cycles and halt flag.
   int m_rem  = 0;
   bit m_halt = 0;

   hazard_detection_unit #(
      .REG_ID_W(REG_ID_W), .LOAD_BR_STALLS(LOAD_BR_STALLS), .ALU_BR_STALLS(ALU_BR_STALLS)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .MemRead_IDEX(MemRead_IDEX), .RegWrite_IDEX(RegWrite_IDEX), .FlagWrite_IDEX(FlagWrite_IDEX),
      .DstReg_IDEX(DstReg_IDEX), .SrcReg1_IFID(SrcReg1_IFID), .SrcReg2_IFID(SrcReg2_IFID),
      .uses_src1(uses_src1), .uses_src2(uses_src2), .is_store_IFID(is_store_IFID),
      .is_br_IFID(is_br_IFID), .is_b_IFID(is_b_IFID), .branch_taken_ID(branch_taken_ID),
      .imem_busy(imem_busy), .dmem_busy(dmem_busy), .hlt_MEMWB(hlt_MEMWB),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Vector order: {pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, halted}
   task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", name, act, req);
      end
   endtask

   task automatic idle();
      MemRead_IDEX = 0; RegWrite_IDEX = 0; FlagWrite_IDEX = 0; DstReg_IDEX = '0;
      SrcReg1_IFID = '0; SrcReg2_IFID = '0; uses_src1 = 0; uses_src2 = 0;
      is_store_IFID = 0; is_br_IFID = 0; is_b_IFID = 0; branch_taken_ID = 0;
      imem_busy = 0; dmem_busy = 0; hlt_MEMWB = 0;
   endtask

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // One cycle: inputs already applied at the falling edge. Evaluate the
   // model, compare, then advance the model across the rising edge.
   task automatic step(input logic [5:0] lit, input bit use_lit, input string name);
      logic [5:0] exp_v, act;
      int  need, nrem;
      bit  pc, ifd, fl, bub, fr, m1, m2, nhalt;
      #1;
      pc = 0; ifd = 0; fl = 0; bub = 0; fr = 0; need = 0;
      m1 = (SrcReg1_IFID == DstReg_IDEX) && (SrcReg1_IFID != 0);
      m2 = (SrcReg2_IFID == DstReg_IDEX) && (SrcReg2_IFID != 0);
      if (MemRead_IDEX && ((uses_src1 && m1) || (uses_src2 && !is_store_IFID && m2)))
         need = imax(need, 1);
      if (is_br_IFID && RegWrite_IDEX && m1)
         need = imax(need, MemRead_IDEX ? LOAD_BR_STALLS : ALU_BR_STALLS);
      if (is_b_IFID && FlagWrite_IDEX)
         need = imax(need, ALU_BR_STALLS);
      nrem = m_rem;
      if (m_halt) begin
         pc = 1; ifd = 1;
      end else if (dmem_busy) begin
         pc = 1; ifd = 1; fr = 1;
      end else if (m_rem > 0) begin
         pc = 1; ifd = 1; bub = 1; nrem = m_rem - 1;
      end else if (need > 0) begin
         pc = 1; ifd = 1; bub = 1; nrem = need - 1;
      end else begin
         if ((is_br_IFID || is_b_IFID) && branch_taken_ID) fl = 1;
         if (imem_busy) begin pc = 1; fl = 1; end
      end
      nhalt = m_halt | hlt_MEMWB;
      exp_v = {pc, ifd, fl, bub, fr, m_halt};
      act   = {pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, halted};
      check(name, act, exp_v);
      if (use_lit) begin
         check({name, "_lit"}, act, lit);
         check({name, "_model"}, exp_v, lit);
      end
      @(posedge clk);
      if (rst_n) begin
         m_rem  = nrem;
         m_halt = nhalt;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 0; m_rem = 0; m_halt = 0;
   endtask

   initial begin
      idle();
      rst_n = 0;
      @(negedge clk);
      step(6'b000000, 1, "reset_state");
      rst_n = 1;
      step(6'b000000, 1, "post_reset");

      // Load-use on src1: one stall then clear
      MemRead_IDEX = 1; RegWrite_IDEX = 1; DstReg_IDEX = 3; SrcReg1_IFID = 3; uses_src1 = 1;
      step(6'b110100, 1, "lu_src1");
      idle();
      step(6'b000000, 1, "lu_src1_after");

      // Store data is bypassed; address is not; r0 never matches
      MemRead_IDEX = 1; RegWrite_IDEX = 1; DstReg_IDEX = 3; is_store_IFID = 1;
      uses_src1 = 1; uses_src2 = 1; SrcReg1_IFID = 5; SrcReg2_IFID = 3;
      step(6'b000000, 1, "sw_data");
      SrcReg1_IFID = 3;
      step(6'b110100, 1, "sw_addr");
      idle();
      MemRead_IDEX = 1; DstReg_IDEX = 0; uses_src1 = 1; uses_src2 = 1;
      step(6'b000000, 1, "r0_nomatch");

      // BR after load: 2 stalls then flush
      idle();
      MemRead_IDEX = 1; RegWrite_IDEX = 1; DstReg_IDEX = 4;
      is_br_IFID = 1; SrcReg1_IFID = 4; uses_src1 = 1; branch_taken_ID = 1;
      step(6'b110100, 1, "br_ld_s1");
      step(6'b110100, 1, "br_ld_s2");
      MemRead_IDEX = 0; RegWrite_IDEX = 0; DstReg_IDEX = 0;
      step(6'b001000, 1, "br_ld_flush");

      // BR after ALU: 1 stall then flush
      MemRead_IDEX = 0; RegWrite_IDEX = 1; DstReg_IDEX = 4;
      step(6'b110100, 1, "br_alu_s1");
      RegWrite_IDEX = 0; DstReg_IDEX = 0;
      step(6'b001000, 1, "br_alu_flush");

      // B on flags: taken and not taken
      idle();
      FlagWrite_IDEX = 1; is_b_IFID = 1; branch_taken_ID = 1;
      step(6'b110100, 1, "b_tk_s1");
      FlagWrite_IDEX = 0;
      step(6'b001000, 1, "b_tk_flush");
      FlagWrite_IDEX = 1; branch_taken_ID = 0;
      step(6'b110100, 1, "b_nt_s1");
      FlagWrite_IDEX = 0;
      step(6'b000000, 1, "b_nt_after");

      // Taken branch with imem_busy: single flush, PC held
      branch_taken_ID = 1; imem_busy = 1;
      step(6'b101000, 1, "br_imem");

      // Counted stall paused by dmem_busy
      idle();
      MemRead_IDEX = 1; RegWrite_IDEX = 1; DstReg_IDEX = 4;
      is_br_IFID = 1; SrcReg1_IFID = 4; uses_src1 = 1; branch_taken_ID = 1;
      step(6'b110100, 1, "frz_s1");
      dmem_busy = 1;
      for (int i = 0; i < 3; i++) step(6'b110010, 1, "frz_hold");
      dmem_busy = 0;
      step(6'b110100, 1, "frz_s2");
      MemRead_IDEX = 0; RegWrite_IDEX = 0; DstReg_IDEX = 0;
      step(6'b001000, 1, "frz_flush");

      // Reset mid-stall discards the count
      idle();
      MemRead_IDEX = 1; RegWrite_IDEX = 1; DstReg_IDEX = 4;
      is_br_IFID = 1; SrcReg1_IFID = 4; uses_src1 = 1;
      step(6'b110100, 1, "rst_s1");
      idle();
      do_reset();
      step(6'b000000, 1, "rst_mid");
      rst_n = 1;
      step(6'b000000, 1, "rst_after");

      // Sticky halt
      hlt_MEMWB = 1;
      step(6'b000000, 1, "hlt_pulse");
      hlt_MEMWB = 0;
      step(6'b110001, 1, "hlt_1");
      dmem_busy = 1;
      step(6'b110001, 1, "hlt_dmem");
      dmem_busy = 0; is_b_IFID = 1; FlagWrite_IDEX = 1; branch_taken_ID = 1;
      step(6'b110001, 1, "hlt_br");
      idle();
      do_reset();
      step(6'b000000, 1, "hlt_rst");
      rst_n = 1;

      // Randomized run against the model
      for (int n = 0; n < 4000; n++) begin
         MemRead_IDEX    = ($urandom_range(0, 2) == 0);
         RegWrite_IDEX   = MemRead_IDEX | ($urandom_range(0, 1) == 0);
         FlagWrite_IDEX  = ($urandom_range(0, 3) == 0);
         DstReg_IDEX     = REG_ID_W'($urandom_range(0, 3));
         SrcReg1_IFID    = REG_ID_W'($urandom_range(0, 3));
         SrcReg2_IFID    = REG_ID_W'($urandom_range(0, 3));
         uses_src1       = $urandom_range(0, 1);
         uses_src2       = $urandom_range(0, 1);
         is_store_IFID   = ($urandom_range(0, 3) == 0);
         is_br_IFID      = ($urandom_range(0, 3) == 0);
         is_b_IFID       = !is_br_IFID && ($urandom_range(0, 3) == 0);
         branch_taken_ID = $urandom_range(0, 1);
         imem_busy       = ($urandom_range(0, 5) == 0);
         dmem_busy       = ($urandom_range(0, 5) == 0);
         hlt_MEMWB       = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 79) == 0) do_reset();
         else rst_n = 1;
         step(6'b000000, 0, "rand");
      end
      rst_n = 1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
